// File: rtl/snn_spike_io.sv
// Multi-channel spike I/O front end: input synchronisers/edge pulses,
// sticky output flags, saturating counters and 4-phase counter readout.
// Optional build macro: SNN_SPIKE_IO_TIMESTAMP_EN (adds rd_tstamp).
module snn_spike_io #(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 16,
  parameter int SEL_WIDTH   =
    ($clog2(NUM_OUTPUTS) > 0) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  spike_in,
  output logic [NUM_INPUTS-1:0]  net_spike_in,
  input  logic [NUM_OUTPUTS-1:0] net_spike_out,
  output logic [NUM_OUTPUTS-1:0] spike_out,
  input  logic                   clear,
  input  logic                   rd_req,
  input  logic [SEL_WIDTH-1:0]   rd_sel,
  output logic                   rd_ack,
  output logic [COUNT_WIDTH-1:0] rd_count
`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
  ,
  output logic [COUNT_WIDTH-1:0] rd_tstamp
`endif
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_ACK
  } rd_state_e;

  logic [NUM_INPUTS-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_INPUTS-1:0]  prev_q;
  logic [COUNT_WIDTH-1:0] cnt_q  [NUM_OUTPUTS];

  rd_state_e              state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                   ack_d;
  logic [COUNT_WIDTH-1:0] rd_count_d;
  logic [COUNT_WIDTH-1:0] snap_cnt;

`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
  logic [COUNT_WIDTH-1:0] ts_q;
  logic [COUNT_WIDTH-1:0] last_q [NUM_OUTPUTS];
  logic [COUNT_WIDTH-1:0] rd_tstamp_d;
  logic [COUNT_WIDTH-1:0] snap_ts;
`endif

  // Pin synchroniser chain plus registered rising-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_q[k] <= '0;
      prev_q       <= '0;
      net_spike_in <= '0;
    end else begin
      sync_q[0] <= spike_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
      prev_q       <= sync_q[SYNC_STAGES-1];
      net_spike_in <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  // Sticky flags and saturating counters; a spike wins over clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spike_out <= '0;
      for (int j = 0; j < NUM_OUTPUTS; j++)
        cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (net_spike_out[j]) begin
          spike_out[j] <= 1'b1;
          if (clear)
            cnt_q[j] <= COUNT_WIDTH'(1);
          else if (cnt_q[j] != CNT_MAX)
            cnt_q[j] <= cnt_q[j] + 1'b1;
        end else if (clear) begin
          spike_out[j] <= 1'b0;
          cnt_q[j]     <= '0;
        end
      end
    end
  end

`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
  // Free-running timestamp and per-channel last-spike time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q <= '0;
      for (int j = 0; j < NUM_OUTPUTS; j++)
        last_q[j] <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (net_spike_out[j])
          last_q[j] <= ts_q;
        else if (clear)
          last_q[j] <= '0;
      end
    end
  end
`endif

  // Selected-channel mux; out-of-range selects read as zero
  always_comb begin
    snap_cnt = '0;
`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
    snap_ts = '0;
`endif
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (sel_q == SEL_WIDTH'(j)) begin
        snap_cnt = cnt_q[j];
`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
        snap_ts = last_q[j];
`endif
      end
    end
  end

  // Readout FSM state and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      rd_ack   <= 1'b0;
      rd_count <= '0;
`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
      rd_tstamp <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rd_ack   <= ack_d;
      rd_count <= rd_count_d;
`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
      rd_tstamp <= rd_tstamp_d;
`endif
    end
  end

  // Readout FSM next-state: IDLE -> SNAP -> ACK -> IDLE
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ack_d      = rd_ack;
    rd_count_d = rd_count;
`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
    rd_tstamp_d = rd_tstamp;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          sel_d   = rd_sel;
          state_d = S_SNAP;
        end
      end
      S_SNAP: begin
        rd_count_d = snap_cnt;
`ifdef SNN_SPIKE_IO_TIMESTAMP_EN
        rd_tstamp_d = snap_ts;
`endif
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!rd_req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
